// File: rtl/rate_counter_pkg.sv
// Shared types and period arithmetic for the rate counter.
// Speed code 0 selects a one-cycle period; code s>=1 selects CLOCK_FREQUENCY * 2**(s-1).
package rate_counter_pkg;

    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } count_mode_t;

    function automatic int unsigned period_of(input int unsigned speed,
                                              input int unsigned clock_frequency);
        if (speed == 32'd0)
            return 32'd1;
        else
            return clock_frequency << (speed - 32'd1);
    endfunction

    // Divider width that holds P-1 for the longest period without truncation.
    function automatic int unsigned div_width(input int unsigned max_period);
        return (max_period > 32'd1) ? $clog2(max_period) : 32'd1;
    endfunction

    localparam int unsigned DEFAULT_CLOCK_FREQUENCY = 500;
    localparam int unsigned DEFAULT_SPEED_WIDTH     = 2;
    localparam int unsigned MAX_PERIOD =
        period_of((32'd1 << DEFAULT_SPEED_WIDTH) - 32'd1, DEFAULT_CLOCK_FREQUENCY);

endpackage

// File: rtl/rate_tick_gen.sv
// Programmable-period tick divider; Tick is combinational from DivCnt and Enable.
// Latency: first tick in the first enabled cycle; Enable low freezes the count (no backpressure).
// Optional: RATE_COUNTER_SPEED_RESTART_EN restarts the period as soon as Speed changes.
module rate_tick_gen
    import rate_counter_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 500,
    parameter int unsigned SPEED_WIDTH     = 2
) (
    input  logic                   ClockIn,
    input  logic                   ResetN,
    input  logic                   Enable,
    input  logic [SPEED_WIDTH-1:0] Speed,
    output logic                   Tick
);

    localparam int unsigned MAX_P = period_of((32'd1 << SPEED_WIDTH) - 32'd1, CLOCK_FREQUENCY);
    localparam int unsigned DIV_W = div_width(MAX_P);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] reload_val;
    logic             restart;

    always_comb reload_val = DIV_W'(period_of(32'(Speed), CLOCK_FREQUENCY) - 32'd1);

`ifdef RATE_COUNTER_SPEED_RESTART_EN
    logic [SPEED_WIDTH-1:0] speed_q;

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN)
            speed_q <= '0;
        else
            speed_q <= Speed;
    end

    assign restart = Enable && (Speed != speed_q);
`else
    assign restart = 1'b0;
`endif

    // Forcing zero makes the next cycle tick and reload with the new period.
    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN)
            div_cnt <= '0;
        else if (restart)
            div_cnt <= '0;
        else if (Enable)
            div_cnt <= (div_cnt == '0) ? reload_val : div_cnt - DIV_W'(1);
    end

    assign Tick = Enable && (div_cnt == '0);

endmodule

// File: rtl/rate_counter_gen2.sv
// Tick-driven up/down counter with limit, wrap/saturate, load and terminal pulse.
// Latency: count and Terminal update on the edge ending a tick cycle; Load overrides, no backpressure.
// Optional: RATE_COUNTER_SPEED_RESTART_EN enables immediate period restart on Speed change.
module rate_counter_gen2
    import rate_counter_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 500,
    parameter int unsigned COUNT_WIDTH     = 4,
    parameter int unsigned SPEED_WIDTH     = 2
) (
    input  logic                   ClockIn,
    input  logic                   ResetN,
    input  logic                   Enable,
    input  logic [SPEED_WIDTH-1:0] Speed,
    input  logic                   Up,
    input  logic                   Saturate,
    input  logic [COUNT_WIDTH-1:0] Limit,
    input  logic                   Load,
    input  logic [COUNT_WIDTH-1:0] LoadValue,
    output logic                   Tick,
    output logic [COUNT_WIDTH-1:0] CounterValue,
    output logic                   Terminal
);

    logic                   tick;
    logic [COUNT_WIDTH-1:0] next_cv;
    logic                   boundary;
    count_mode_t            mode;

    rate_tick_gen #(
        .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
        .SPEED_WIDTH     (SPEED_WIDTH)
    ) u_tick_gen (
        .ClockIn (ClockIn),
        .ResetN  (ResetN),
        .Enable  (Enable),
        .Speed   (Speed),
        .Tick    (tick)
    );

    assign Tick = tick;
    assign mode = Saturate ? SATURATE : WRAP;

    // A count above Limit going down snaps to Limit; that is a correction, not a boundary.
    always_comb begin
        next_cv  = CounterValue;
        boundary = 1'b0;
        if (Up) begin
            if (CounterValue >= Limit) begin
                boundary = 1'b1;
                next_cv  = (mode == SATURATE) ? Limit : '0;
            end else begin
                next_cv = CounterValue + COUNT_WIDTH'(1);
            end
        end else begin
            if (CounterValue == '0) begin
                boundary = 1'b1;
                next_cv  = (mode == SATURATE) ? '0 : Limit;
            end else if (CounterValue > Limit) begin
                next_cv = Limit;
            end else begin
                next_cv = CounterValue - COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            CounterValue <= '0;
            Terminal     <= 1'b0;
        end else if (Load) begin
            CounterValue <= (LoadValue > Limit) ? Limit : LoadValue;
            Terminal     <= 1'b0;
        end else if (tick) begin
            CounterValue <= next_cv;
            Terminal     <= boundary;
        end else begin
            Terminal     <= 1'b0;
        end
    end

endmodule

// File: doc/rate_counter_gen2.md
Name: rate_counter_gen2

Overview:
- Parametrised successor to the fixed four-speed rate divider and 4-bit display counter pair.
- Combines a programmable-period tick generator with a configurable counter:
  - Up/down direction; limit modulus; wrap or saturate mode; synchronous load; terminal-count pulse.
- Sits between board-level clock/switch inputs and display/decoder logic.
- Drives HEX counters and timed sequencers.

Parameters:
- CLOCK_FREQUENCY, 500, input clock cycles per 1 s base period.
- COUNT_WIDTH, 4, width of CounterValue, LoadValue and Limit.
- SPEED_WIDTH, 2, width of Speed; number of speed codes = 2**SPEED_WIDTH.

Ports:
- ClockIn  input  1  single clock; all state on posedge.
- ResetN  input  1  asynchronous, active-low reset.
- Enable  input  1  run; low freezes divider and counter.
- Speed  input  SPEED_WIDTH  period select (see Behaviour).
- Up  input  1  1 = count up, 0 = count down.
- Saturate  input  1  1 = saturate at boundary, 0 = wrap.
- Limit  input  COUNT_WIDTH  inclusive upper count bound.
- Load  input  1  synchronous load strobe.
- LoadValue  input  COUNT_WIDTH  value applied on Load.
- Tick  output  1  divider pulse; combinational from state.
- CounterValue  output  COUNT_WIDTH  registered count.
- Terminal  output  1  registered one-cycle boundary pulse.

Behaviour:
- Reset (ResetN=0, async, any time incl. mid-count):
  - DivCnt=0, CounterValue=0, Terminal=0; internal Speed copy=0.
  - Tick follows from DivCnt=0.
- Period P(s):
  - s=0: P=1, tick every enabled cycle.
  - s>=1: P = CLOCK_FREQUENCY * 2**(s-1).
  - DivCnt width = $clog2(max P); no truncation allowed.
- Tick = Enable && (DivCnt==0).
- Divider, per clock:
  - Enable=0: hold.
  - else DivCnt==0: reload P(Speed)-1.
  - else: DivCnt-1.
- First tick after reset release with Enable=1 occurs in the first cycle; later ticks every P cycles.
- Counter priority, per clock: Load > Tick step > hold.
  - Load: CounterValue <= (LoadValue > Limit) ? Limit : LoadValue.
  - Load does not touch the divider and is honoured even with Enable=0.
  - Load never asserts Terminal.
- Tick step, Up=1:
  - CounterValue >= Limit: boundary. Wrap mode -> 0; saturate mode -> Limit.
  - Otherwise +1.
- Tick step, Up=0:
  - CounterValue == 0: boundary. Wrap mode -> Limit; saturate mode -> 0.
  - CounterValue > Limit: -> Limit, not a boundary.
  - Otherwise -1.
- Terminal: registered; high for exactly the cycle after any boundary step.
  - Saturated boundary steps pulse Terminal on every tick.
- Limit=0: every tick is a boundary; CounterValue stays 0.
- Speed, Up, Saturate and Limit changes are sampled on each tick or reload; no glitch on outputs.

Optional Feature:
- Macro: RATE_COUNTER_SPEED_RESTART_EN.
- Defined:
  - Internal registered copy of Speed compared each cycle.
  - On change with Enable=1, DivCnt <= 0 that clock, so a tick occurs next cycle and the new period starts immediately.
  - Copy resets to 0.
- Undefined:
  - No copy register.
  - New Speed takes effect only at the next natural reload, so up to old P-1 cycles of latency.

Decomposition:
- Package rate_counter_pkg:
  - function period_of(speed, CLOCK_FREQUENCY).
  - localparam MAX_PERIOD.
  - enum count_mode_t {WRAP, SATURATE}.
- Natural sub-module: rate_tick_gen (divider + optional restart logic), instantiated once.
- Counter/terminal logic stays in the top module.

Test Plan:
- Reset then Enable=1, Speed=1, CLOCK_FREQUENCY=5, Up=1, Saturate=0, Limit=15 -> Tick at cycles 0,5,10,…; CounterValue 0→1→…→15→0; Terminal one-cycle pulse after the 15→0 step.
- Speed=3, CLOCK_FREQUENCY=5 -> Tick period 20 cycles; Speed=0 -> Tick every cycle; Enable=0 mid-period -> DivCnt and CounterValue frozen, resume with the same remaining count.
- Saturate=1, Up=0 from CounterValue=2 -> 1,0,0,0; Terminal pulses on the 2nd and 3rd ticks at 0, not on the 1→0 step.
- Limit=9, Load=1 with LoadValue=12 -> CounterValue=9, no Terminal; the next Up tick -> 0 with Terminal; Load coinciding with Tick -> load wins.
- Assert ResetN=0 asynchronously between edges mid-count (CounterValue=7) -> outputs cleared immediately, before the next ClockIn edge.
- Macro defined, Speed 2→1 mid-period -> Tick the next cycle, then period CLOCK_FREQUENCY; undefined -> old period finishes first.
